store_write_buffer: RTL and testbench

Posted-write buffer between the CPU's MEM-stage store outputs and the word-addressed data memory. Sized SB/SH/SW requests are aligned into byte lanes with byte enables, then queued in a small FIFO. Entries drain to memory one per cycle under a ready handshake, so the pipeline does not stall on memory write latency. A combinational load-hazard probe lets the CPU stall a load whose word address matches a pending store. A flush handshake drains the buffer completely, for example before an I/O access or halt.

---
 rtl/sopc_pkg.sv | 32 +++
 rtl/store_lane_align.sv | 55 +++++
 rtl/store_write_buffer.sv | 151 +++++++++++++++
 tb/tb_store_write_buffer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sopc_pkg
//  Description : Shared types and constants for the store write buffer.
//                Holds the store length codes, the flush FSM state encoding,
//                and the lane-aligned payload struct that makes up a buffer
//                entry (the top level adds the word address, whose width is
//                a top-level parameter).
//  Revision    : 1.0  initial release
// ============================================================================
package sopc_pkg;

  // Store length codes as presented by the MEM stage
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Flush sequencing states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } swb_state_e;

  // Lane-aligned write payload: byte enables plus replicated write data
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lane_t;

endpackage : sopc_pkg
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : store_lane_align
//  Description : Combinational store aligner. Replicates the significant low
//                bytes of the register data across the word and derives the
//                byte enables from the low address bits and the length code.
//                Unknown length codes produce legal_o=0 and zero payload.
//  Ports       : addr_lo_i  byte address bits [1:0]
//                len_i      length code (LEN_B / LEN_H / LEN_W)
//                data_i     unaligned register data
//                wdata_o    lane-aligned write data
//                be_o       byte enables, bit i covers wdata_o[8i+7:8i]
//                legal_o    length code is one of the supported sizes
//  Revision    : 1.0  initial release
// ============================================================================
module store_lane_align
  import sopc_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  len_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        legal_o
);

  always_comb begin
    wdata_o = '0;
    be_o    = '0;
    legal_o = 1'b0;
    case (len_i)
      LEN_B: begin
        wdata_o = {4{data_i[7:0]}};
        be_o    = 4'b0001 << addr_lo_i;
        legal_o = 1'b1;
      end
      LEN_H: begin
        // Halfword lane is chosen by bit 1 only; bit 0 is ignored.
        wdata_o = {2{data_i[15:0]}};
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        legal_o = 1'b1;
      end
      LEN_W: begin
        wdata_o = data_i;
        be_o    = 4'b1111;
        legal_o = 1'b1;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule : store_lane_align
`default_nettype wire

// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_write_buffer
//  Description : Posted-write buffer between the MEM-stage store port and the
//                word-addressed data memory. Stores are lane-aligned and
//                queued in a DEPTH-entry FIFO, drained one per cycle under
//                mem_ready. A combinational probe flags loads that hit a
//                pending store word, and a flush handshake drains the queue.
//  Ports       : clock, reset            clock / synchronous active-high reset
//                st_valid/st_ready       store handshake
//                st_addr/st_data/st_len  store byte address, data, length code
//                ld_valid/ld_addr        load probe inputs
//                ld_hazard               load matches a pending store word
//                mem_we/mem_ready        memory write handshake (head entry)
//                mem_addr/wdata/be       head entry word address and payload
//                flush_req/flush_done    drain request / completion pulse
//                count                   number of valid entries
//  Parameters  : DEPTH  FIFO entries, power of two, 2..16
//                AW     word-address width, at most 29
//  Revision    : 1.0  initial release
// ============================================================================
module store_write_buffer
  import sopc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 7
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [31:0]                  st_addr,
  input  logic [31:0]                  st_data,
  input  logic [2:0]                   st_len,
  input  logic                         ld_valid,
  input  logic [31:0]                  ld_addr,
  output logic                         ld_hazard,
  output logic                         mem_we,
  output logic [AW-1:0]                mem_addr,
  output logic [31:0]                  mem_wdata,
  output logic [3:0]                   mem_be,
  input  logic                         mem_ready,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] addr;
    lane_t         lane;
  } entry_t;

  entry_t         fifo_q [DEPTH];
  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q;
  swb_state_e     state_q, state_d;

  logic [31:0]    lane_wdata;
  logic [3:0]     lane_be;
  logic           lane_legal;
  logic           push, pop;
  entry_t         head_e;
  logic           hit;
  logic [PW-1:0]  offs;

  // Address bits outside the word index are not part of the match/entry.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[31:AW+2], ld_addr[31:AW+2], ld_addr[1:0]};

  store_lane_align u_align (
    .addr_lo_i (st_addr[1:0]),
    .len_i     (st_len),
    .data_i    (st_data),
    .wdata_o   (lane_wdata),
    .be_o      (lane_be),
    .legal_o   (lane_legal)
  );

  // Full-buffer check uses the registered count only, so a same-cycle pop
  // never opens a slot for a push.
  assign st_ready = (count_q != CW'(DEPTH)) && (state_q == RUN);
  // Illegal lengths complete the handshake but never enqueue.
  assign push     = st_valid && st_ready && lane_legal;
  assign mem_we   = (count_q != '0);
  assign pop      = mem_we && mem_ready;

  assign head_e    = fifo_q[head_q];
  assign mem_addr  = mem_we ? head_e.addr       : '0;
  assign mem_wdata = mem_we ? head_e.lane.wdata : '0;
  assign mem_be    = mem_we ? head_e.lane.be    : '0;
  assign count     = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else begin
      state_q <= state_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; validity is defined by head/count.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[tail_q] <= '{addr: st_addr[AW+1:2],
                          lane: '{be: lane_be, wdata: lane_wdata}};
    end
  end

  // Slot i is valid when its distance from the head is below count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head_q;
      if ((CW'(offs) < count_q) && (fifo_q[i].addr == ld_addr[AW+1:2])) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_valid && hit;

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      RUN:     if (flush_req) state_d = DRAIN;
      DRAIN:   if (count_q == '0) state_d = DONE;
      DONE: begin
        flush_done = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule : store_write_buffer
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_write_buffer
//  Description : Self-checking bench for store_write_buffer. A queue-based
//                reference model follows the buffer contents and flush
//                sequencing; a compare process checks every output against it
//                each cycle, and directed tests pin literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 7;

  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_len;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        flush_req;
  logic        flush_done;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_len     (st_len),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hazard  (ld_hazard),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .count      (count)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [6:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int   mst = 0;   // 0 run, 1 draining, 2 done

  function automatic bit align(input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] len, output ent_t e);
    e.addr  = a[8:2];
    e.be    = 4'b0;
    e.wdata = 32'b0;
    case (len)
      3'd1: begin e.wdata = {24'b0, d[7:0]} * 32'h0101_0101; e.be = 4'b0001 << a[1:0]; return 1'b1; end
      3'd2: begin e.wdata = {16'b0, d[15:0]} * 32'h0001_0001; e.be = a[1] ? 4'b1100 : 4'b0011; return 1'b1; end
      3'd4: begin e.wdata = d; e.be = 4'b1111; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clock) begin
    int   sz;
    bit   acc, pp, lg;
    ent_t e;
    if (reset) begin
      q.delete();
      mst = 0;
    end else begin
      sz  = q.size();
      acc = st_valid && (sz < DEPTH) && (mst == 0);
      pp  = (sz > 0) && mem_ready;
      lg  = align(st_addr, st_data, st_len, e);
      case (mst)
        0: if (flush_req) mst = 1;
        1: if (sz == 0) mst = 2;
        default: mst = 0;
      endcase
      if (pp) void'(q.pop_front());
      if (acc && lg) q.push_back(e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------- compare process
  always @(negedge clock) begin
    logic [31:0] ew, ea;
    logic [3:0]  eb;
    bit          eh;
    if (chk_en) begin
      ew = 32'b0; ea = 32'b0; eb = 4'b0; eh = 1'b0;
      if (q.size() > 0) begin
        ea = {25'b0, q[0].addr};
        ew = q[0].wdata;
        eb = q[0].be;
      end
      foreach (q[i]) if (ld_valid && q[i].addr == ld_addr[8:2]) eh = 1'b1;
      check("m_count",     {29'b0, count}, q.size());
      check("m_st_ready",  {31'b0, st_ready}, {31'b0, (q.size() < DEPTH) && (mst == 0)});
      check("m_mem_we",    {31'b0, mem_we}, {31'b0, q.size() > 0});
      check("m_mem_addr",  {25'b0, mem_addr}, ea);
      check("m_mem_wdata", mem_wdata, ew);
      check("m_mem_be",    {28'b0, mem_be}, {28'b0, eb});
      check("m_ld_hazard", {31'b0, ld_hazard}, {31'b0, eh});
      check("m_flush_done",{31'b0, flush_done}, {31'b0, mst == 2});
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    st_valid = v; st_addr = a; st_data = d; st_len = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int zc, dc, n;
    reset = 1'b1; st_valid = 0; st_addr = 0; st_data = 0; st_len = 0;
    ld_valid = 0; ld_addr = 0; mem_ready = 0; flush_req = 0;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_count",      {29'b0, count}, 32'd0);
    check("rst_st_ready",   {31'b0, st_ready}, 32'd1);
    check("rst_mem_we",     {31'b0, mem_we}, 32'd0);
    check("rst_flush_done", {31'b0, flush_done}, 32'd0);

    // Single SB
    mem_ready = 1'b1;
    drive_st(1, 32'h0000_0006, 32'h1234_56AB, 3'd1);
    tick();
    drive_st(0, 0, 0, 0);
    #1;
    check("sb_mem_we",    {31'b0, mem_we}, 32'd1);
    check("sb_mem_addr",  {25'b0, mem_addr}, 32'd1);
    check("sb_mem_be",    {28'b0, mem_be}, 32'h4);
    check("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    tick();
    check("sb_drained", {29'b0, count}, 32'd0);

    // Fill and backpressure
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_st(1, 32'h100 + 4*i, 32'hA000_0000 + i, 3'd4);
      #1;
      if (i == 4) begin
        check("full_st_ready", {31'b0, st_ready}, 32'd0);
        check("full_count",    {29'b0, count}, 32'd4);
      end
      tick();
    end
    drive_st(0, 0, 0, 0);
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("fill_order_addr",  {25'b0, mem_addr}, 32'h40 + i);
      check("fill_order_wdata", mem_wdata, 32'hA000_0000 + i);
      tick();
    end
    check("fill_drained", {29'b0, count}, 32'd0);

    // Simultaneous push/pop at count=2 with pointer wrap
    mem_ready = 1'b0;
    drive_st(1, 32'h10, 32'h0000_1111, 3'd2);
    tick();
    drive_st(1, 32'h12, 32'h0000_2222, 3'd2);
    #1;
    check("sh_lo_be", {28'b0, mem_be}, 32'h3);
    tick();
    mem_ready = 1'b1;
    ld_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_st(1, 32'h80 + 4*k, 32'hC000_0000 + k, 3'd4);
      ld_addr = 32'h80 + 4*k;
      #1;
      check("pp_count", {29'b0, count}, 32'd2);
      if (k == 0) check("pp_head0", mem_wdata, 32'h1111_1111);
      else if (k == 1) check("pp_head1_be", {28'b0, mem_be}, 32'hC);
      else check("pp_order", mem_wdata, 32'hC000_0000 + k - 2);
      tick();
    end
    drive_st(0, 0, 0, 0);
    ld_valid = 1'b0;
    tick(); tick();
    check("pp_drained", {29'b0, count}, 32'd0);

    // Load hazard
    mem_ready = 1'b0;
    drive_st(1, 32'h40, 32'h0000_5555, 3'd2);
    tick();
    drive_st(0, 0, 0, 0);
    ld_valid = 1'b1; ld_addr = 32'h42;
    #1;
    check("hz_same_word", {31'b0, ld_hazard}, 32'd1);
    ld_addr = 32'h44;
    #1;
    check("hz_other_word", {31'b0, ld_hazard}, 32'd0);
    mem_ready = 1'b1;
    tick();
    ld_addr = 32'h42;
    #1;
    check("hz_after_drain", {31'b0, ld_hazard}, 32'd0);
    ld_valid = 1'b0;

    // Flush with 3 entries queued
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_st(1, 32'h20 + 4*i, 32'h7000_0000 + i, 3'd4);
      tick();
    end
    drive_st(0, 0, 0, 0);
    flush_req = 1'b1; mem_ready = 1'b1;
    tick();
    flush_req = 1'b0;
    drive_st(1, 32'h60, 32'hDEAD_BEEF, 3'd4);   // must be refused while draining
    zc = -1; dc = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (count == 0 && zc < 0) zc = c;
      if (flush_done) begin dc = c; break; end
      check("fl_st_ready", {31'b0, st_ready}, 32'd0);
      tick();
    end
    drive_st(0, 0, 0, 0);
    check("fl_done_seen", {31'b0, dc >= 0}, 32'd1);
    check("fl_done_delay", dc - zc, 32'd1);
    tick();
    check("fl_done_pulse", {31'b0, flush_done}, 32'd0);
    check("fl_ready_back", {31'b0, st_ready}, 32'd1);

    // Flush on empty buffer
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 1;
    while (!flush_done && n < 4) begin tick(); n++; end
    check("fl_empty_within2", {31'b0, flush_done && n <= 2}, 32'd1);
    tick();

    // Illegal length, then reset during operation
    mem_ready = 1'b0;
    drive_st(1, 32'h20, 32'h1357_9BDF, 3'd3);
    #1;
    check("ill_st_ready", {31'b0, st_ready}, 32'd1);
    tick();
    drive_st(0, 0, 0, 0);
    check("ill_count", {29'b0, count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_st(1, 32'h30 + 4*i, 32'h5000_0000 + i, 3'd4);
      tick();
    end
    drive_st(0, 0, 0, 0);
    check("rr_count_before", {29'b0, count}, 32'd3);
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_mem_we",  {31'b0, mem_we}, 32'd0);
    check("rr_count",   {29'b0, count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_no_write", {31'b0, mem_we}, 32'd0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_store_write_buffer
`default_nettype wire
